// File: rtl/frog_input_ctrl.sv
// frog_input_ctrl
//   Turns USB HID key presses into grid hops for the frog.
//   New W/A/S/D or arrow presses are queued as hop commands. Each command is
//   executed as one STEP-pixel hop animated over HOP_FRAMES VGA frames.
//
// Ports
//   Clk           system clock (50 MHz)
//   Reset_n       asynchronous active-low reset
//   keycode       two HID key slots: [7:0] slot 0, [15:8] slot 1, 0x00 = none
//   frame_clk     VGA vertical sync, asynchronous to Clk
//   respawn       1-cycle pulse: return frog to start, flush queued commands
//   FrogX/FrogY   frog top-left pixel position
//   FrogDir       facing: 0 up, 1 down, 2 left, 3 right
//   hop_active    high while a hop animation is in progress
//   forward_pulse 1-cycle pulse after an up-hop completes
//   overflow      sticky: a command was dropped because the queue was full
module frog_input_ctrl #(
    parameter int unsigned STEP       = 32,
    parameter int unsigned HOP_FRAMES = 4,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned START_X    = 320,
    parameter int unsigned START_Y    = 448,
    parameter int unsigned MAX_X      = 608,
    parameter int unsigned MAX_Y      = 448
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [15:0] keycode,
    input  logic        frame_clk,
    input  logic        respawn,
    output logic [9:0]  FrogX,
    output logic [9:0]  FrogY,
    output logic [1:0]  FrogDir,
    output logic        hop_active,
    output logic        forward_pulse,
    output logic        overflow
);

    typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;
    typedef enum logic {S_IDLE, S_HOP} state_t;

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned HC_W  = $clog2(HOP_FRAMES + 1);

    localparam logic [10:0] HOP_STEP   = 11'(STEP);
    localparam logic [9:0]  FRAME_STEP = 10'(STEP / HOP_FRAMES);
    localparam logic [9:0]  X0         = 10'(START_X);
    localparam logic [9:0]  Y0         = 10'(START_Y);
    localparam logic [10:0] XMAX       = 11'(MAX_X);
    localparam logic [10:0] YMAX       = 11'(MAX_Y);

    // {mapped, direction}
    function automatic logic [2:0] decode_key(input logic [7:0] code);
        case (code)
            8'h1A, 8'h52: decode_key = {1'b1, DIR_UP};
            8'h16, 8'h51: decode_key = {1'b1, DIR_DOWN};
            8'h04, 8'h50: decode_key = {1'b1, DIR_LEFT};
            8'h07, 8'h4F: decode_key = {1'b1, DIR_RIGHT};
            default:      decode_key = 3'b000;
        endcase
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        ptr_inc = (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // ---------------- key detection / hold register ----------------
    logic [7:0] prev0, prev1;
    logic [2:0] dec0, dec1;
    logic       new0, new1;
    logic       hold_valid;
    dir_t       hold_dir;
    logic       push_req, load_hold;
    dir_t       push_dir;

    always_comb begin
        dec0 = decode_key(keycode[7:0]);
        dec1 = decode_key(keycode[15:8]);
        // Compare against both previous slots so a key shifting slots is not a new press
        new0 = dec0[2] && (keycode[7:0]  != 8'h00) && (keycode[7:0]  != prev0) && (keycode[7:0]  != prev1);
        new1 = dec1[2] && (keycode[15:8] != 8'h00) && (keycode[15:8] != prev0) && (keycode[15:8] != prev1);

        push_req  = 1'b0;
        push_dir  = DIR_UP;
        load_hold = 1'b0;
        if (hold_valid) begin
            push_req = 1'b1;
            push_dir = hold_dir;
        end else if (new0) begin
            push_req  = 1'b1;
            push_dir  = dir_t'(dec0[1:0]);
            load_hold = new1;
        end else if (new1) begin
            push_req = 1'b1;
            push_dir = dir_t'(dec1[1:0]);
        end
    end

    // ---------------- command FIFO ----------------
    dir_t             mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] fifo_cnt;
    logic             fifo_empty, fifo_full;
    logic             push, pop, drop;
    dir_t             fifo_head;

    state_t           state;
    logic             tick;

    always_comb begin
        fifo_empty = (fifo_cnt == '0);
        fifo_full  = (fifo_cnt == CNT_W'(FIFO_DEPTH));
        fifo_head  = mem[rd_ptr];
        pop        = (state == S_IDLE) && tick && !fifo_empty && !respawn;
        push       = push_req && (!fifo_full || pop) && !respawn;
        drop       = push_req && fifo_full && !pop && !respawn;
    end

    always_ff @(posedge Clk) begin
        if (push)
            mem[wr_ptr] <= push_dir;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            prev0      <= '0;
            prev1      <= '0;
            hold_valid <= 1'b0;
            hold_dir   <= DIR_UP;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_cnt   <= '0;
            overflow   <= 1'b0;
        end else begin
            prev0 <= keycode[7:0];
            prev1 <= keycode[15:8];
            if (respawn) begin
                hold_valid <= 1'b0;
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                fifo_cnt   <= '0;
                overflow   <= 1'b0;
            end else begin
                hold_valid <= load_hold;
                if (load_hold)
                    hold_dir <= dir_t'(dec1[1:0]);
                if (push)
                    wr_ptr <= ptr_inc(wr_ptr);
                if (pop)
                    rd_ptr <= ptr_inc(rd_ptr);
                case ({push, pop})
                    2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                    2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                    default: fifo_cnt <= fifo_cnt;
                endcase
                if (drop)
                    overflow <= 1'b1;
            end
        end
    end

    // ---------------- frame tick ----------------
    logic fs1, fs2, fs3;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            fs1  <= 1'b0;
            fs2  <= 1'b0;
            fs3  <= 1'b0;
            tick <= 1'b0;
        end else begin
            fs1  <= frame_clk;
            fs2  <= fs1;
            fs3  <= fs2;
            tick <= fs2 & ~fs3;
        end
    end

    // ---------------- hop FSM ----------------
    dir_t            dir_q;
    dir_t            move_dir;
    logic [HC_W-1:0] hop_cnt, cnt_next;
    logic            target_ok;
    logic [9:0]      step_x, step_y;

    always_comb begin
        move_dir = (state == S_IDLE) ? fifo_head : dir_q;
        cnt_next = hop_cnt + 1'b1;
        case (fifo_head)
            DIR_UP:    target_ok = {1'b0, FrogY} >= HOP_STEP;
            DIR_DOWN:  target_ok = ({1'b0, FrogY} + HOP_STEP) <= YMAX;
            DIR_LEFT:  target_ok = {1'b0, FrogX} >= HOP_STEP;
            default:   target_ok = ({1'b0, FrogX} + HOP_STEP) <= XMAX;
        endcase
        step_x = FrogX;
        step_y = FrogY;
        case (move_dir)
            DIR_UP:    step_y = FrogY - FRAME_STEP;
            DIR_DOWN:  step_y = FrogY + FRAME_STEP;
            DIR_LEFT:  step_x = FrogX - FRAME_STEP;
            default:   step_x = FrogX + FRAME_STEP;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state         <= S_IDLE;
            FrogX         <= X0;
            FrogY         <= Y0;
            dir_q         <= DIR_UP;
            hop_cnt       <= '0;
            forward_pulse <= 1'b0;
        end else begin
            forward_pulse <= 1'b0;
            if (respawn) begin
                state   <= S_IDLE;
                FrogX   <= X0;
                FrogY   <= Y0;
                dir_q   <= DIR_UP;
                hop_cnt <= '0;
            end else if (tick) begin
                case (state)
                    S_IDLE: begin
                        if (!fifo_empty) begin
                            dir_q <= fifo_head;
                            if (target_ok) begin
                                FrogX <= step_x;
                                FrogY <= step_y;
                                if (HOP_FRAMES == 1) begin
                                    forward_pulse <= (fifo_head == DIR_UP);
                                end else begin
                                    state   <= S_HOP;
                                    hop_cnt <= HC_W'(1);
                                end
                            end
                        end
                    end
                    S_HOP: begin
                        FrogX   <= step_x;
                        FrogY   <= step_y;
                        hop_cnt <= cnt_next;
                        if (cnt_next == HC_W'(HOP_FRAMES)) begin
                            state         <= S_IDLE;
                            forward_pulse <= (dir_q == DIR_UP);
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign FrogDir    = dir_q;
    assign hop_active = (state == S_HOP);

endmodule

// File: tb/tb_frog_input_ctrl.sv
`timescale 1ns/1ps
module tb_frog_input_ctrl;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic [15:0] keycode;
    logic        frame_clk;
    logic        respawn;
    logic [9:0]  FrogX, FrogY;
    logic [1:0]  FrogDir;
    logic        hop_active, forward_pulse, overflow;

    int tests_run    = 0;
    int tests_failed = 0;
    int fp_count     = 0;
    int hop_count    = 0;

    frog_input_ctrl #(
        .STEP(32), .HOP_FRAMES(4), .FIFO_DEPTH(4),
        .START_X(320), .START_Y(448), .MAX_X(608), .MAX_Y(448)
    ) dut (
        .Clk(Clk), .Reset_n(Reset_n), .keycode(keycode), .frame_clk(frame_clk),
        .respawn(respawn), .FrogX(FrogX), .FrogY(FrogY), .FrogDir(FrogDir),
        .hop_active(hop_active), .forward_pulse(forward_pulse), .overflow(overflow)
    );

    always #10 Clk = ~Clk;

    always @(negedge Clk) begin
        if (forward_pulse === 1'b1) fp_count++;
        if (hop_active === 1'b1)    hop_count++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic frame_tick();
        frame_clk = 1'b1;
        wait_clk(8);
        frame_clk = 1'b0;
        wait_clk(8);
    endtask

    task automatic press(input logic [15:0] code);
        keycode = code;
        wait_clk(1);
        keycode = 16'h0000;
        wait_clk(2);
    endtask

    task automatic do_reset();
        Reset_n   = 1'b0;
        keycode   = 16'h0000;
        frame_clk = 1'b0;
        respawn   = 1'b0;
        wait_clk(3);
        Reset_n = 1'b1;
        wait_clk(2);
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++; if (FrogX !== 10'd320) begin tests_failed++; $display("FAIL reset_x got %0d want 320", FrogX); end
        tests_run++; if (FrogY !== 10'd448) begin tests_failed++; $display("FAIL reset_y got %0d want 448", FrogY); end
        tests_run++; if (FrogDir !== 2'd0) begin tests_failed++; $display("FAIL reset_dir got %0d want 0", FrogDir); end
        tests_run++; if ({hop_active, forward_pulse, overflow} !== 3'b000) begin tests_failed++; $display("FAIL reset_flags got %b want 000", {hop_active, forward_pulse, overflow}); end
    endtask

    task automatic test_up_hop();
        int exp_y [4] = '{440, 432, 424, 416};
        int fp0;
        do_reset();
        fp0 = fp_count;
        press(16'h001A);
        for (int i = 0; i < 4; i++) begin
            frame_tick();
            tests_run++; if (FrogY !== 10'(exp_y[i])) begin tests_failed++; $display("FAIL up_y tick%0d got %0d want %0d", i + 1, FrogY, exp_y[i]); end
            tests_run++; if (hop_active !== (i < 3)) begin tests_failed++; $display("FAIL up_active tick%0d got %b want %b", i + 1, hop_active, (i < 3)); end
            tests_run++; if (fp_count - fp0 !== ((i == 3) ? 1 : 0)) begin tests_failed++; $display("FAIL up_fpulse tick%0d got %0d want %0d", i + 1, fp_count - fp0, (i == 3) ? 1 : 0); end
        end
        tests_run++; if (FrogDir !== 2'd0) begin tests_failed++; $display("FAIL up_dir got %0d want 0", FrogDir); end
    endtask

    task automatic test_blocked_down();
        int h0;
        do_reset();
        h0 = hop_count;
        press(16'h0051);
        frame_tick();
        tests_run++; if (FrogDir !== 2'd1) begin tests_failed++; $display("FAIL blk_dir got %0d want 1", FrogDir); end
        tests_run++; if (FrogY !== 10'd448) begin tests_failed++; $display("FAIL blk_y got %0d want 448", FrogY); end
        tests_run++; if (hop_count != h0) begin tests_failed++; $display("FAIL blk_active got %0d cycles want 0", hop_count - h0); end
        // queue must now be empty: a W press must be the next command executed
        press(16'h001A);
        frame_tick();
        tests_run++; if (FrogY !== 10'd440) begin tests_failed++; $display("FAIL blk_next_y got %0d want 440", FrogY); end
    endtask

    task automatic test_two_slots();
        int exp_x [8] = '{312, 304, 296, 288, 296, 304, 312, 320};
        do_reset();
        press(16'h0704);
        for (int i = 0; i < 8; i++) begin
            frame_tick();
            tests_run++; if (FrogX !== 10'(exp_x[i])) begin tests_failed++; $display("FAIL two_x tick%0d got %0d want %0d", i + 1, FrogX, exp_x[i]); end
            if (i == 3) begin
                tests_run++; if (FrogDir !== 2'd2) begin tests_failed++; $display("FAIL two_dir_left got %0d want 2", FrogDir); end
            end
        end
        tests_run++; if (FrogDir !== 2'd3) begin tests_failed++; $display("FAIL two_dir_right got %0d want 3", FrogDir); end
        tests_run++; if (FrogY !== 10'd448) begin tests_failed++; $display("FAIL two_y got %0d want 448", FrogY); end
    endtask

    task automatic test_no_repeat();
        int fp0;
        do_reset();
        fp0 = fp_count;
        keycode = 16'h001A;
        for (int i = 0; i < 10; i++) frame_tick();
        keycode = 16'h0000;
        frame_tick();
        frame_tick();
        tests_run++; if (FrogY !== 10'd416) begin tests_failed++; $display("FAIL rep_y got %0d want 416", FrogY); end
        tests_run++; if (fp_count - fp0 != 1) begin tests_failed++; $display("FAIL rep_fpulse got %0d want 1", fp_count - fp0); end
    endtask

    task automatic test_overflow_respawn();
        do_reset();
        press(16'h0007);
        press(16'h0004);
        press(16'h0007);
        press(16'h0004);
        tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL ovf_at_full got %b want 0", overflow); end
        press(16'h0007);
        tests_run++; if (overflow !== 1'b1) begin tests_failed++; $display("FAIL ovf_set got %b want 1", overflow); end
        press(16'h0004);
        respawn = 1'b1;
        wait_clk(1);
        respawn = 1'b0;
        wait_clk(1);
        tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL ovf_clear got %b want 0", overflow); end
        frame_tick();
        tests_run++; if ({FrogX, FrogY} !== {10'd320, 10'd448}) begin tests_failed++; $display("FAIL ovf_pos got %0d,%0d want 320,448", FrogX, FrogY); end
        tests_run++; if (hop_active !== 1'b0) begin tests_failed++; $display("FAIL ovf_flushed got hop_active %b want 0", hop_active); end
    endtask

    task automatic test_respawn_mid_hop();
        int exp_y [4] = '{440, 432, 424, 416};
        int fp0;
        do_reset();
        fp0 = fp_count;
        press(16'h001A);
        frame_tick();
        tests_run++; if (FrogY !== 10'd440) begin tests_failed++; $display("FAIL rsp_first_y got %0d want 440", FrogY); end
        // second tick: internal tick lands 3 edges after the rise, respawn shares that cycle
        frame_clk = 1'b1;
        wait_clk(3);
        respawn = 1'b1;
        wait_clk(1);
        respawn = 1'b0;
        wait_clk(4);
        frame_clk = 1'b0;
        wait_clk(8);
        tests_run++; if (FrogY !== 10'd448) begin tests_failed++; $display("FAIL rsp_y got %0d want 448", FrogY); end
        tests_run++; if (hop_active !== 1'b0) begin tests_failed++; $display("FAIL rsp_active got %b want 0", hop_active); end
        frame_tick();
        tests_run++; if (FrogY !== 10'd448) begin tests_failed++; $display("FAIL rsp_idle_y got %0d want 448", FrogY); end
        press(16'h001A);
        for (int i = 0; i < 4; i++) begin
            frame_tick();
            tests_run++; if (FrogY !== 10'(exp_y[i])) begin tests_failed++; $display("FAIL rsp_new_y tick%0d got %0d want %0d", i + 1, FrogY, exp_y[i]); end
        end
        tests_run++; if (fp_count - fp0 != 1) begin tests_failed++; $display("FAIL rsp_fpulse got %0d want 1", fp_count - fp0); end
    endtask

    task automatic test_reset_mid_hop();
        do_reset();
        press(16'h001A);
        frame_tick();
        Reset_n = 1'b0;
        wait_clk(1);
        tests_run++; if ({FrogY, hop_active} !== {10'd448, 1'b0}) begin tests_failed++; $display("FAIL rst_mid got y=%0d act=%b want 448,0", FrogY, hop_active); end
        Reset_n = 1'b1;
        wait_clk(2);
        frame_tick();
        tests_run++; if (FrogY !== 10'd448) begin tests_failed++; $display("FAIL rst_mid_after got %0d want 448", FrogY); end
    endtask

    initial begin
        test_reset();
        test_up_hop();
        test_blocked_down();
        test_two_slots();
        test_no_repeat();
        test_overflow_respawn();
        test_respawn_mid_hop();
        test_reset_mid_hop();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/frog_input_ctrl.md
Name: frog_input_ctrl

Overview:
- Sits between the NIOS keycode PIO (keycode[15:0], two USB HID key slots) and frogger_game / color_mapper.
- Detects new key presses (W/A/S/D and arrow keys) and queues them as hop commands.
- Executes one grid hop per command, animated over several VGA frames.
- Drives the frog's pixel position, facing direction, hop status and a forward-hop pulse used for scoring.

Parameters:
STEP, 32, hop distance in pixels (one grid tile)
HOP_FRAMES, 4, frames per hop; power of 2 that divides STEP; per-frame step = STEP/HOP_FRAMES
FIFO_DEPTH, 4, command queue depth
START_X, 320, respawn X (pixels)
START_Y, 448, respawn Y (pixels)
MAX_X, 608, largest legal X (640-STEP)
MAX_Y, 448, largest legal Y (480-STEP); minimum X and minimum Y are both 0

Ports:
Clk  in  1  50 MHz system clock
Reset_n  in  1  asynchronous, active-low reset
keycode  in  16  HID key slots from NIOS; [7:0] = slot 0, [15:8] = slot 1; 0x00 = no key
frame_clk  in  1  VGA_VS, asynchronous to Clk
respawn  in  1  1-cycle pulse from frogger_game (death or goal reached)
FrogX  out  10  frog top-left X
FrogY  out  10  frog top-left Y
FrogDir  out  2  facing: 0 up, 1 down, 2 left, 3 right
hop_active  out  1  high while a hop animation is in progress
forward_pulse  out  1  1-cycle pulse when an up-hop completes
overflow  out  1  sticky; set when a command is dropped because the FIFO is full

Behaviour:
- Reset (async assert, sync release):
  - FrogX=START_X, FrogY=START_Y, FrogDir=0.
  - hop_active=0, forward_pulse=0, overflow=0.
  - FIFO empty, hold register empty, previous-key registers = 0x00, state IDLE.
- Key map:
  - up: 0x1A (W), 0x52
  - down: 0x16 (S), 0x51
  - left: 0x04 (A), 0x50
  - right: 0x07 (D), 0x4F
  - Every other code is ignored.
- New-press detection, per slot:
  - A slot is new when its code is mapped, non-zero, and differs from both slot values registered on the previous Clk.
  - A key that moves from slot 1 to slot 0 is therefore not re-detected.
- Push ordering:
  - At most one FIFO push per cycle.
  - If both slots are new in the same cycle, slot 0 is pushed that cycle and slot 1 is parked in a 1-entry hold register.
  - The hold register pushes on the next cycle, with priority over any new detection in that cycle (a new detection then is dropped).
- Push latency: a detected press enters the FIFO on the next Clk edge.
- FIFO full: the command is dropped and overflow is set. Push and pop in the same cycle are both allowed when the FIFO is full.
- Frame tick:
  - frame_clk passes through a 2-flop synchronizer, then rising-edge detect.
  - Result is a 1-cycle tick, 3–4 Clk cycles after the VS rising edge.
- FSM states: IDLE, HOP.
  - IDLE, tick, FIFO non-empty:
    - Pop one command and set FrogDir to its direction.
    - If the target (current position ± STEP) is outside [0,MAX_X] or [0,MAX_Y], discard the command: no movement, stay IDLE.
    - Otherwise apply one per-frame step, set cnt=1 and go to HOP (or complete immediately if HOP_FRAMES=1).
  - HOP, tick: apply one per-frame step and increment cnt. When cnt reaches HOP_FRAMES, the hop is complete: return to IDLE.
  - Hop completion with direction up: forward_pulse=1 for the cycle after completion.
  - Ticks with an empty FIFO in IDLE: no effect.
  - Commands queued during a hop wait; the earliest next pop is the tick after completion.
- hop_active = (state==HOP).
- Arithmetic is unsigned 10-bit. The bounds check guarantees no wrap-around.
- respawn has highest priority and takes effect on the next edge, overriding a pop, step or push in the same cycle:
  - FrogX=START_X, FrogY=START_Y, FrogDir=0, state IDLE.
  - FIFO and hold register flushed; overflow cleared; no forward_pulse.
- Reset mid-hop: all state returns to reset values; the partial hop is lost.

Test Plan:
1. Reset_n low, then high; keycode 0x001A; 4 frame ticks → FrogDir=0; FrogY 448→440→432→424→416 on successive ticks; hop_active high from tick 1 until tick 4; one forward_pulse after tick 4.
2. From reset, keycode 0x0051 (down at Y=448) → FrogDir=1, FrogY stays 448, hop_active never asserts, FIFO empty after the tick.
3. keycode 0x0704 in one cycle (A and D together) → FIFO holds left then right; after 8 ticks FrogX = 320 (left 320→288, then right back to 320); FrogDir=3.
4. Hold 0x001A for 10 frames, then release → exactly one hop (no auto-repeat); FrogY=416.
5. Six distinct presses (D, 0, A, 0, D, 0, …) with no frame ticks → first 4 queued, 5th and 6th dropped, overflow=1; then respawn pulse → overflow=0, FIFO empty, FrogX=320, FrogY=448.
6. respawn asserted on the same cycle as the 2nd tick of an up-hop → FrogY=448, hop_active=0, no forward_pulse; a subsequent W press starts a fresh 4-frame hop.
